branch_predictor: RTL

- Direction predictor for conditional branches, downstream of the execute-stage branch condition generator.
- Consumes the resolved branch outcome (branch seen, branch taken) to train a gshare table of 2-bit saturating counters.
- Supplies a taken/not-taken prediction to fetch, plus the table index the pipeline carries to execute.
- Flags mispredicts at resolution so the hazard unit can flush.

---
 rtl/bp_pkg.sv | 31 +++
 rtl/bp_sat_ctr.sv | 28 ++
 rtl/branch_predictor.sv | 106 ++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch predictor:
// the 2-bit counter encoding, default geometry and saturating step functions.
package bp_pkg;

  localparam int DEF_IDX_W = 6;
  localparam int DEF_GHR_W = 6;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // Step toward strongly-taken, holding at ST.
  function automatic ctr_t sat_inc(input ctr_t c);
    ctr_t r;
    if (c == ST) r = ST;
    else         r = ctr_t'(c + 2'd1);
    return r;
  endfunction

  // Step toward strongly-not-taken, holding at SNT.
  function automatic ctr_t sat_dec(input ctr_t c);
    ctr_t r;
    if (c == SNT) r = SNT;
    else          r = ctr_t'(c - 2'd1);
    return r;
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// One 2-bit saturating direction counter. Loads RESET_VAL while rst_n is
// low and steps up (inc=1) or down (inc=0) on edges where en is high.
module bp_sat_ctr
  import bp_pkg::*;
#(
  parameter logic [1:0] RESET_VAL = 2'b01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       inc,
  output logic [1:0] ctr
);

  ctr_t ctr_q;

  // Counter state: async reset, saturating step when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_q <= ctr_t'(RESET_VAL);
    end else if (en) begin
      ctr_q <= inc ? sat_inc(ctr_q) : sat_dec(ctr_q);
    end
  end

  assign ctr = ctr_q;

endmodule

// File: rtl/branch_predictor.sv
// gshare conditional-branch direction predictor.
// Fetch side: predIdx = fetchPc[IDX_W+1:2] ^ ghr, predTaken = counter MSB,
// both purely combinational. Resolve side: an unkilled resolved branch
// (upd = updValid & ~updKill) trains table[updIdx] and shifts the outcome
// into the non-speculative global history. A write and a read of the same
// entry in one cycle are not bypassed: the read sees the old counter.
// Optional macro BRANCH_PREDICTOR_STATS_EN enables saturating resolved-branch
// and mispredict counters; without it brCount/mispCount are constant zero.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int         IDX_W     = DEF_IDX_W,
  parameter int         GHR_W     = DEF_GHR_W,
  parameter logic [1:0] RESET_CTR = 2'b01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      fetchPc,
  output logic             predTaken,
  output logic [IDX_W-1:0] predIdx,
  input  logic             updValid,
  input  logic             updTaken,
  input  logic             updPredTaken,
  input  logic [IDX_W-1:0] updIdx,
  input  logic             updKill,
  output logic             mispredict,
  output logic [31:0]      brCount,
  output logic [31:0]      mispCount
);

  localparam int DEPTH = 1 << IDX_W;

  if (GHR_W > IDX_W || GHR_W < 1) begin : g_bad_cfg
    $error("branch_predictor: GHR_W must be in 1..IDX_W");
  end

  logic             upd;
  logic [GHR_W-1:0] ghr;
  logic [IDX_W-1:0] ghr_ext;
  logic [1:0]       ctr_q [DEPTH];
  logic             unused_pc;

  // Killed branches (flush/interrupt) neither train nor report.
  assign upd        = updValid & ~updKill;
  assign mispredict = upd & (updTaken != updPredTaken);

  // History occupies the low bits of the index; upper bits come from PC only.
  assign ghr_ext   = IDX_W'(ghr);
  assign predIdx   = fetchPc[IDX_W+1:2] ^ ghr_ext;
  assign predTaken = ctr_q[predIdx][1];

  // PC bits outside the index window do not participate in the lookup.
  assign unused_pc = &{1'b0, fetchPc[31:IDX_W+2], fetchPc[1:0]};

  // One saturating counter per table entry, written only at updIdx.
  for (genvar i = 0; i < DEPTH; i++) begin : g_table
    bp_sat_ctr #(
      .RESET_VAL (RESET_CTR)
    ) u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (upd && (updIdx == IDX_W'(i))),
      .inc   (updTaken),
      .ctr   (ctr_q[i])
    );
  end

  if (GHR_W == 1) begin : g_ghr_1
    // Single-bit history simply records the last resolved outcome.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   ghr <= '0;
      else if (upd) ghr <= updTaken;
    end
  end else begin : g_ghr_n
    // Shift the resolved outcome into the history LSB.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   ghr <= '0;
      else if (upd) ghr <= {ghr[GHR_W-2:0], updTaken};
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] br_cnt;
  logic [31:0] misp_cnt;

  // Saturating event counters: they stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt   <= '0;
      misp_cnt <= '0;
    end else begin
      if (upd && (br_cnt != 32'hFFFF_FFFF))
        br_cnt <= br_cnt + 32'd1;
      if (mispredict && (misp_cnt != 32'hFFFF_FFFF))
        misp_cnt <= misp_cnt + 32'd1;
    end
  end

  assign brCount   = br_cnt;
  assign mispCount = misp_cnt;
`else
  assign brCount   = 32'h0;
  assign mispCount = 32'h0;
`endif

endmodule
